demux8_loader: RTL
==================

Name: demux8_loader

Overview:
- Write-side counterpart of the 8:1 selector: owns eight WIDTH-bit holding registers (Out0..Out7) that feed the selector's In0..In7 inputs.
- Loads registers either one at a time (addressed write, 3-bit select S) or as a sequential burst of eight values over a valid/ready stream.
- Used to load palette and sprite-index tables, for example at level start.

Parameters:
- WIDTH, 5: data width of every slot and of Din.
- RESET_VAL, 0: value every slot takes on Reset and on Clr.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clr  input  1  pulse; sets all slots to RESET_VAL.
- WrEn  input  1  single addressed write request.
- S  input  3  slot select for WrEn.
- Start  input  1  pulse; begins burst fill of slots 0..7.
- Din  input  WIDTH  write data, used by both single-write and burst modes.
- Din_valid  input  1  burst data valid.
- Din_ready  output  1  block accepts burst data this cycle.
- Busy  output  1  high while the FSM is not in IDLE.
- Done  output  1  one-cycle pulse after the 8th burst word is written.
- Ptr  output  3  next burst slot index, for debug and HUD.
- Out0..Out7  output  WIDTH each  registered slot contents.

Behaviour:
- Reset (asynchronous, active-high):
  - Out0..Out7 = RESET_VAL.
  - State = IDLE, Ptr = 0.
  - Din_ready = 0, Busy = 0, Done = 0.
  - Reset asserted mid-burst aborts the burst immediately. Slots already written revert to RESET_VAL.
- FSM states: IDLE, FILL, DONE.
- IDLE priority, highest first: Clr > Start > WrEn. Lower-priority requests in the same cycle are dropped, not queued.
  - Clr: all slots = RESET_VAL on the next edge; stay in IDLE.
  - Start: Ptr = 0; go to FILL.
  - WrEn: Out[S] = Din on the next edge; latency 1 cycle; other slots unchanged; stay in IDLE.
- FILL:
  - Din_ready = 1.
  - On each edge with Din_valid = 1: Out[Ptr] = Din, Ptr = Ptr + 1.
  - Din_valid = 0 stalls the burst with no write and no Ptr change; there is no timeout.
  - When the word accepted is at Ptr = 7: Ptr wraps to 0 and the FSM goes to DONE.
  - WrEn, Start and Clr are ignored in FILL.
- DONE:
  - Done = 1 for exactly one cycle; Din_ready = 0.
  - Unconditionally return to IDLE; all requests are ignored in this cycle.
- Output flags:
  - Busy = (state != IDLE).
  - Done is asserted only in DONE.
  - Din_ready is asserted only in FILL.
- Data path:
  - No arithmetic on data; Din is stored verbatim at WIDTH bits.
  - Ptr is a 3-bit counter with natural wrap 7 -> 0.
- Visibility: a write to a slot is visible on OutN the cycle after the accepting edge. A selector reading the slot sees the new value with the same 1-cycle delay.
- All outputs are registered except Din_ready, Busy and Done, which decode the state register directly and carry no input-to-output combinational path.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, DONE} loader_state_t;
  - localparam SLOT_W = 5;
  - localparam NUM_SLOTS = 8.
- One natural sub-module, demux8_dec: a combinational 3-to-8 one-hot write-enable decoder from the write index (S in IDLE, Ptr in FILL) gated by the write strobe.
- The eight registers and the FSM live in the top module.

Test Plan:
- Reset check: assert Reset mid-run -> all OutN = 0, Busy = 0, Din_ready = 0 immediately, without waiting for a Clk edge.
- Single write: WrEn = 1, S = 3'b101, Din = 5'h1A for one cycle -> Out5 = 5'h1A one cycle later; the other seven slots remain 0.
- Burst with stalls: Start pulse, then feed Din = 1..8 with Din_valid low every third cycle ->
  - Out0..Out7 = 1..8;
  - Done pulses exactly once, the cycle after the 8th accept;
  - Ptr returns to 0;
  - Busy falls the cycle after Done.
- Priority in IDLE: after preloading Out2 = 5'h07, drive Clr, Start and WrEn (S = 2, Din = 5'h1F) in the same cycle -> all slots = 0, FSM remains IDLE, no burst starts.
- Ignored requests in FILL: mid-burst at Ptr = 3, drive WrEn (S = 0, Din = 5'h11) and Clr -> Out0 keeps its burst value, no clear occurs, and the burst completes normally.
- Reset mid-burst: after 4 words accepted, pulse Reset -> all slots = 0, state IDLE, Ptr = 0. A subsequent Start and full burst loads correctly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and sizes for the tile/palette loading blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } loader_state_t;

    localparam int SLOT_W    = 5;
    localparam int NUM_SLOTS = 8;

endpackage

// File: rtl/demux8_dec.sv
// 3-to-8 one-hot write-enable decoder; all enables low when the strobe is low.
module demux8_dec
    import game_pkg::*;
(
    input  logic [2:0]           idx,
    input  logic                 stb,
    output logic [NUM_SLOTS-1:0] onehot
);

    // Raise exactly one enable for the addressed slot while the strobe is high.
    always_comb begin
        onehot = '0;
        if (stb) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux8_loader.sv
// Eight holding registers loaded by single addressed writes or an
// eight-word burst. The burst input is a valid/ready stream: a word is
// accepted on a rising Clk edge where Din_valid and Din_ready are both high;
// Din_ready depends only on the state register, never on Din_valid.
module demux8_loader
    import game_pkg::*;
#(
    parameter int               WIDTH     = SLOT_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             WrEn,
    input  logic [2:0]       S,
    input  logic             Start,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_valid,
    output logic             Din_ready,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       Ptr,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [WIDTH-1:0] Out4,
    output logic [WIDTH-1:0] Out5,
    output logic [WIDTH-1:0] Out6,
    output logic [WIDTH-1:0] Out7
);

    loader_state_t        state_q;
    loader_state_t        state_d;
    logic [2:0]           ptr_q;
    logic [2:0]           ptr_d;
    logic [2:0]           wr_idx;
    logic                 wr_stb;
    logic                 clr_all;
    logic [NUM_SLOTS-1:0] wr_oh;
    logic [WIDTH-1:0]     slot_q [NUM_SLOTS];

    // State and burst pointer registers; reset aborts any burst in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state, pointer and write controls; IDLE resolves Clr > Start > WrEn.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_idx  = S;
        wr_stb  = 1'b0;
        clr_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (Clr) begin
                    clr_all = 1'b1;
                end else if (Start) begin
                    ptr_d   = 3'd0;
                    state_d = FILL;
                end else if (WrEn) begin
                    wr_stb = 1'b1;
                end
            end
            FILL: begin
                wr_idx = ptr_q;
                if (Din_valid) begin
                    wr_stb = 1'b1;
                    ptr_d  = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    demux8_dec u_dec (
        .idx    (wr_idx),
        .stb    (wr_stb),
        .onehot (wr_oh)
    );

    // Slot storage: clear wins over writes; only the decoded slot is loaded.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= RESET_VAL;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_oh[i]) begin
                    slot_q[i] <= Din;
                end
            end
        end
    end

    assign Din_ready = (state_q == FILL);
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
    assign Ptr       = ptr_q;

    assign Out0 = slot_q[0];
    assign Out1 = slot_q[1];
    assign Out2 = slot_q[2];
    assign Out3 = slot_q[3];
    assign Out4 = slot_q[4];
    assign Out5 = slot_q[5];
    assign Out6 = slot_q[6];
    assign Out7 = slot_q[7];

endmodule
